// File: rtl/pixel_fetch.sv
// pixel_fetch: converts the serpentine scan position into a linear SRAM
// address, performs one single-beat read per position, and streams the
// pixel with its coordinates. It also drives the scan generator's clear and
// advance pulses.
module pixel_fetch #(
  parameter int SIZE   = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [SIZE-1:0]   max_x,
  input  logic [SIZE-1:0]   max_y,
  input  logic [SIZE-1:0]   curr_x,
  input  logic [SIZE-1:0]   curr_y,
  input  logic              end_pos,
  output logic              new_trans,
  output logic              update_pos,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic [SIZE-1:0]   pix_x,
  output logic [SIZE-1:0]   pix_y,
  output logic              busy,
  output logic              done
);

  // Sum width wide enough for both the base and the full row*width product;
  // the result is then truncated to the address width.
  localparam int SUM_W = (ADDR_W > 2*SIZE) ? ADDR_W : 2*SIZE;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    REQ,
    WAIT,
    OUT,
    STEP,
    FINISH
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [SIZE-1:0]   width_q;
  logic              last_q;
  logic [ADDR_W-1:0] addr_q;

  logic [2*SIZE-1:0] row_off;
  logic [SUM_W-1:0]  addr_sum;
  logic [ADDR_W-1:0] req_addr;

  // Linear address of the live scan position. The frame height is not
  // needed after start: it only gates the empty-frame check, and the scan
  // generator owns the row count through end_pos.
  always_comb begin
    row_off  = (2*SIZE)'(curr_y) * (2*SIZE)'(width_q);
    addr_sum = SUM_W'(base_q) + SUM_W'(row_off) + SUM_W'(curr_x);
    req_addr = addr_sum[ADDR_W-1:0];
  end

  // In REQ the scan generator's current coordinate drives the address
  // directly. Afterwards the latched copy holds, because the generator may
  // already have moved on or cleared.
  assign mem_addr   = (state == REQ) ? req_addr : addr_q;
  assign mem_ren    = (state == REQ);
  assign new_trans  = (state == CLEAR);
  assign update_pos = (state == STEP);
  assign pix_valid  = (state == OUT);
  assign done       = (state == FINISH);
  assign busy       = (state != IDLE);

  // Frame sequencing: clear the scanner, then per position read, wait,
  // present and advance until the position flagged as last is accepted.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state    <= IDLE;
      base_q   <= '0;
      width_q  <= '0;
      last_q   <= 1'b0;
      addr_q   <= '0;
      pix_data <= '0;
      pix_x    <= '0;
      pix_y    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            width_q <= max_x;
            if ((max_x == '0) || (max_y == '0)) begin
              state <= FINISH;
            end else begin
              state <= CLEAR;
            end
          end
        end
        CLEAR: begin
          state <= REQ;
        end
        REQ: begin
          addr_q <= req_addr;
          pix_x  <= curr_x;
          pix_y  <= curr_y;
          last_q <= end_pos;
          state  <= WAIT;
        end
        WAIT: begin
          if (mem_rvalid) begin
            pix_data <= mem_rdata;
            state    <= OUT;
          end
        end
        OUT: begin
          if (pix_ready) begin
            if (last_q) begin
              state <= FINISH;
            end else begin
              state <= STEP;
            end
          end
        end
        STEP: begin
          state <= REQ;
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_fetch.sv
// tb_pixel_fetch: scoreboard bench for pixel_fetch. It uses a behavioural
// serpentine scan generator, a variable-latency SRAM and a downstream
// consumer that can apply backpressure.
module tb_pixel_fetch;

  typedef struct {
    logic [7:0] data;
    logic [3:0] x;
    logic [3:0] y;
  } pix_t;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [15:0] base_addr;
  logic [3:0]  max_x;
  logic [3:0]  max_y;
  logic [3:0]  curr_x;
  logic [3:0]  curr_y;
  logic        end_pos;
  logic        new_trans;
  logic        update_pos;
  logic        mem_ren;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_rvalid;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_data;
  logic [3:0]  pix_x;
  logic [3:0]  pix_y;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int scanW, scanH, memLat, stallIdx, stallLen;
  bit spurEn;
  bit zeroFrame;
  int startCyc;

  int renCnt = 0, updCnt = 0, ntCnt = 0, doneCnt = 0, stallCyc = 0, lastHsCyc = 0;

  pix_t        expQ[$];
  logic [15:0] expAddrQ[$];

  int sx, sy;
  bit pend;
  int memCnt;
  logic [15:0] paddr;
  int rdyHs, rdyStall;

  pixel_fetch #(.SIZE(4), .ADDR_W(16), .DATA_W(8)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .base_addr  (base_addr),
    .max_x      (max_x),
    .max_y      (max_y),
    .curr_x     (curr_x),
    .curr_y     (curr_y),
    .end_pos    (end_pos),
    .new_trans  (new_trans),
    .update_pos (update_pos),
    .mem_ren    (mem_ren),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] memData(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Serpentine scan generator: clears on new_trans or after its last
  // position, and steps on update_pos.
  assign curr_x  = 4'(sx);
  assign curr_y  = 4'(sy);
  assign end_pos = (sy == scanH - 1) && (((sy % 2) == 0) ? (sx == scanW - 1) : (sx == 0));

  always @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      sx <= 0;
      sy <= 0;
    end else if (new_trans || end_pos) begin
      sx <= 0;
      sy <= 0;
    end else if (update_pos) begin
      if ((sy % 2) == 0) begin
        if (sx == scanW - 1) sy <= sy + 1;
        else sx <= sx + 1;
      end else begin
        if (sx == 0) sy <= sy + 1;
        else sx <= sx - 1;
      end
    end
  end

  // SRAM with memLat cycles of read latency. Between responses the data
  // bus carries junk, and spurious rvalids can be injected while a pixel
  // is being presented.
  always @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= 8'h00;
      pend       <= 1'b0;
      memCnt     <= 0;
      paddr      <= 16'h0;
    end else begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= 8'hA5;
      if (mem_ren) begin
        if (memLat <= 1) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= memData(mem_addr);
        end else begin
          pend   <= 1'b1;
          memCnt <= memLat - 1;
          paddr  <= mem_addr;
        end
      end else if (pend) begin
        if (memCnt <= 1) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= memData(paddr);
          pend       <= 1'b0;
        end else begin
          memCnt <= memCnt - 1;
        end
      end else if (spurEn && pix_valid) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= 8'hEE;
      end
    end
  end

  // Downstream consumer: it holds ready low for stallLen presented cycles
  // on pixel index stallIdx of the current frame.
  always @(posedge clk or posedge n_rst) begin
    int hsN, cN;
    if (n_rst) begin
      rdyHs     <= 0;
      rdyStall  <= 0;
      pix_ready <= 1'b1;
    end else begin
      hsN = rdyHs;
      cN  = rdyStall;
      if (new_trans) begin
        hsN = 0;
        cN  = 0;
      end else begin
        if (pix_valid && pix_ready) hsN = hsN + 1;
        if (pix_valid && !pix_ready) cN = cN + 1;
      end
      rdyHs     <= hsN;
      rdyStall  <= cN;
      pix_ready <= !((hsN == stallIdx) && (cN < stallLen));
    end
  end

  // Monitor: checks each read address and each accepted pixel against the
  // scoreboard, and checks stability and quiet strobes during stalls.
  always @(negedge clk) begin
    logic [15:0] ea;
    pix_t e;
    if (!n_rst) begin
      if (mem_ren) begin
        renCnt <= renCnt + 1;
        if (expAddrQ.size() > 0) begin
          ea = expAddrQ.pop_front();
          checkOutput("mem_addr", 32'(mem_addr), 32'(ea));
        end else begin
          checkOutput("ren_unexpected", 32'(mem_ren), 32'd0);
        end
      end
      if (update_pos) updCnt <= updCnt + 1;
      if (new_trans) ntCnt <= ntCnt + 1;
      if (update_pos || new_trans)
        checkOutput("upd_nt_exclusive", 32'(update_pos & new_trans), 32'd0);
      if (pix_valid && pix_ready) begin
        lastHsCyc <= cyc;
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          checkOutput("pix_data", 32'(pix_data), 32'(e.data));
          checkOutput("pix_x", 32'(pix_x), 32'(e.x));
          checkOutput("pix_y", 32'(pix_y), 32'(e.y));
        end else begin
          checkOutput("hs_unexpected", 32'(pix_valid), 32'd0);
        end
      end else if (pix_valid) begin
        stallCyc <= stallCyc + 1;
        checkOutput("stall_ren", 32'(mem_ren), 32'd0);
        checkOutput("stall_upd", 32'(update_pos), 32'd0);
        if (expQ.size() > 0) begin
          checkOutput("stall_data", 32'(pix_data), 32'(expQ[0].data));
          checkOutput("stall_x", 32'(pix_x), 32'(expQ[0].x));
          checkOutput("stall_y", 32'(pix_y), 32'(expQ[0].y));
        end
      end
      if (done) begin
        doneCnt <= doneCnt + 1;
        if (zeroFrame) checkOutput("done_zero_frame", 32'(cyc), 32'(startCyc + 1));
        else checkOutput("done_after_hs", 32'(cyc), 32'(lastHsCyc + 1));
      end
    end
  end

  task automatic pushFrame(input logic [15:0] base, input int w, input int h);
    for (int y = 0; y < h; y++) begin
      for (int k = 0; k < w; k++) begin
        int x;
        pix_t e;
        logic [15:0] a;
        x = ((y % 2) == 0) ? k : (w - 1 - k);
        a = base + 16'(y * w + x);
        e.data = memData(a);
        e.x    = 4'(x);
        e.y    = 4'(y);
        expQ.push_back(e);
        expAddrQ.push_back(a);
      end
    end
  endtask

  task automatic applyStimulus(input logic [15:0] base, input int w, input int h,
                               input int lat, input int sIdx, input int sLen,
                               input bit spur, input bit abuseStart);
    int n, upd0, nt0, ren0, done0, st0;
    bit seen;
    n = w * h;
    memLat   = lat;
    stallIdx = sIdx;
    stallLen = sLen;
    spurEn   = spur;
    scanW    = w;
    scanH    = h;
    upd0  = updCnt;
    nt0   = ntCnt;
    ren0  = renCnt;
    done0 = doneCnt;
    st0   = stallCyc;
    pushFrame(base, w, h);
    @(posedge clk); #1;
    base_addr = base;
    max_x     = 4'(w);
    max_y     = 4'(h);
    start     = 1'b1;
    zeroFrame = (n == 0);
    startCyc  = cyc;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = ~base;
    max_x     = 4'd15;
    max_y     = 4'd15;
    @(negedge clk);
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    if (n > 0) checkOutput("new_trans_first", 32'(new_trans), 32'd1);
    if (abuseStart) begin
      repeat (5) @(posedge clk);
      #1;
      base_addr = 16'h0000;
      max_x     = 4'd1;
      max_y     = 4'd1;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    seen = 1'b0;
    if (done) seen = 1'b1;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) checkOutput("done_timeout", 32'(seen), 32'd1);
    #1;
    checkOutput("upd_count", 32'(updCnt - upd0), 32'((n > 0) ? n - 1 : 0));
    checkOutput("nt_count", 32'(ntCnt - nt0), 32'((n > 0) ? 1 : 0));
    checkOutput("ren_count", 32'(renCnt - ren0), 32'(n));
    checkOutput("done_count", 32'(doneCnt - done0), 32'd1);
    checkOutput("exp_left", 32'(expQ.size()), 32'd0);
    if (sIdx >= 0 && sIdx < n) checkOutput("stall_cycles", 32'(stallCyc - st0), 32'(sLen));
    if (abuseStart) begin
      base_addr = 16'h0040;
      max_x     = 4'd2;
      max_y     = 4'd2;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      checkOutput("start_on_finish_ignored", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence: reset, reset during presentation, then the frame set.
  initial begin
    bit hit;
    n_rst     = 1'b1;
    start     = 1'b0;
    base_addr = 16'h0;
    max_x     = 4'd0;
    max_y     = 4'd0;
    memLat    = 1;
    stallIdx  = -1;
    stallLen  = 0;
    spurEn    = 1'b0;
    scanW     = 1;
    scanH     = 1;
    zeroFrame = 1'b0;
    startCyc  = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("rst_mem_ren", 32'(mem_ren), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_new_trans", 32'(new_trans), 32'd0);
    checkOutput("rst_update_pos", 32'(update_pos), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_pix_data", 32'(pix_data), 32'd0);
    n_rst = 1'b0;

    // Reset while the first pixel is being presented and held by the consumer.
    memLat   = 1;
    stallIdx = 0;
    stallLen = 1000;
    scanW    = 3;
    scanH    = 2;
    pushFrame(16'h0100, 3, 2);
    @(posedge clk); #1;
    base_addr = 16'h0100;
    max_x     = 4'd3;
    max_y     = 4'd2;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (pix_valid) hit = 1'b1;
    end
    checkOutput("midrst_reached_out", 32'(hit), 32'd1);
    #2;
    n_rst = 1'b1;
    #1;
    checkOutput("midrst_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_pix_data", 32'(pix_data), 32'd0);
    checkOutput("midrst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    expQ.delete();
    expAddrQ.delete();
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b0;

    // Nominal 3x2 frame, single-cycle memory, consumer always ready.
    applyStimulus(16'h0100, 3, 2, 1, -1, 0, 1'b0, 1'b0);
    // Backpressure on pixel 2, plus start pulses while busy and on FINISH.
    applyStimulus(16'h0200, 3, 2, 1, 1, 7, 1'b0, 1'b1);
    // Longer read latencies with spurious rvalid during a stalled OUT.
    applyStimulus(16'h0300, 2, 2, 4, 0, 3, 1'b1, 1'b0);
    applyStimulus(16'h0400, 2, 2, 9, 0, 3, 1'b1, 1'b0);
    // Empty frames.
    applyStimulus(16'h1234, 0, 3, 1, -1, 0, 1'b0, 1'b0);
    applyStimulus(16'h1234, 3, 0, 1, -1, 0, 1'b0, 1'b0);
    // Single pixel at the top of memory.
    applyStimulus(16'hFFFF, 1, 1, 1, -1, 0, 1'b0, 1'b0);
    // Address wrap around 2^16.
    applyStimulus(16'hFFF0, 4, 8, 2, -1, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_fetch.md
Name: pixel_fetch

Overview:
Fetch controller that sits directly downstream of the serpentine scan-position generator in the FAST corner pipeline. It reads the current (x, y) scan coordinate and converts it to a linear SRAM address (base + y*width + x). It issues a single-beat read and presents the returned pixel with its coordinates on a valid/ready stream. It then pulses update_pos back to the scan generator to advance to the next position, and raises new_trans to clear the scan generator at the start of each frame.

Parameters:
SIZE, 4, coordinate/dimension width (matches scan generator SIZE)
ADDR_W, 16, SRAM address width
DATA_W, 8, pixel width

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous, active-high reset (1 = reset asserted)
start  in  1  one-cycle frame start request
base_addr  in  ADDR_W  frame base address, sampled on accepted start
max_x  in  SIZE  frame width, sampled on accepted start
max_y  in  SIZE  frame height, sampled on accepted start
curr_x  in  SIZE  current scan x from scan generator
curr_y  in  SIZE  current scan y from scan generator
end_pos  in  1  scan generator at last position
new_trans  out  1  clear pulse to scan generator
update_pos  out  1  advance pulse to scan generator
mem_ren  out  1  SRAM read strobe, one cycle per read
mem_addr  out  ADDR_W  SRAM read address
mem_rdata  in  DATA_W  SRAM read data
mem_rvalid  in  1  read data valid, 1+ cycles after mem_ren
pix_valid  out  1  output pixel valid
pix_ready  in  1  downstream ready
pix_data  out  DATA_W  pixel value
pix_x  out  SIZE  pixel x coordinate
pix_y  out  SIZE  pixel y coordinate
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last pixel handshake

Behaviour:
- Reset (n_rst=1, async): state=IDLE. All outputs are 0, including pix_data, pix_x, pix_y and mem_addr. Latched base, width, height and the last flag are cleared.
- States: IDLE, CLEAR, REQ, WAIT, OUT, STEP, FINISH.
- IDLE: start=1 latches base_addr, max_x and max_y.
  - If max_x==0 or max_y==0, go to FINISH (no reads).
  - Otherwise go to CLEAR.
- CLEAR: new_trans=1 for exactly one cycle, then go to REQ.
- REQ (one cycle):
  - mem_ren=1.
  - mem_addr = (base + curr_y*width + curr_x) mod 2^ADDR_W. Product is 2*SIZE bits, zero-extended; sum is truncated.
  - Latch curr_x into pix_x, curr_y into pix_y, and end_pos into the last flag. Latching is mandatory because the scan generator clears its counters on the edge after end_pos.
  - Go to WAIT.
- WAIT: mem_addr holds, mem_ren=0. On mem_rvalid=1, capture mem_rdata into pix_data and go to OUT. No timeout.
- OUT: pix_valid=1. pix_data, pix_x and pix_y are stable until the handshake (pix_valid & pix_ready).
  - On handshake with last=1, go to FINISH.
  - On handshake with last=0, go to STEP.
  - pix_ready may be held high permanently; the minimum OUT duration is 1 cycle.
- STEP: update_pos=1 for exactly one cycle, then go to REQ. REQ samples the advanced coordinate.
- FINISH: done=1 for one cycle, then go to IDLE.
- Throughput with zero-wait memory (rvalid on the cycle after ren) and pix_ready=1 is 4 cycles per pixel: REQ, WAIT, OUT, STEP.
- start is ignored while busy=1. mem_rvalid is ignored outside WAIT. update_pos and new_trans are never high together.
- Reset asserted mid-frame returns to IDLE immediately. An in-flight SRAM response is discarded. The next frame's CLEAR re-synchronises the scan generator.
- Changing base_addr, max_x or max_y while busy has no effect on the current frame.

Test Plan:
- Reset mid-OUT (pix_valid=1) -> all outputs 0 asynchronously, IDLE, busy=0. Subsequent start runs a clean frame beginning with a new_trans pulse.
- Frame 3x2, base=0x0100, real scan generator, 1-cycle memory, pix_ready=1:
  - Pixel order and addresses: (0,0)@0x0100, (1,0)@0x0101, (2,0)@0x0102, (2,1)@0x0105, (1,1)@0x0104, (0,1)@0x0103.
  - 6 update_pos pulses fewer by one (5 total), done on the cycle after the 6th handshake.
- Backpressure: pix_ready low for 7 cycles on pixel 2 -> pix_valid held, data/coords stable, no mem_ren or update_pos until acceptance.
- Variable latency: mem_rvalid after 1, 4 and 9 cycles -> one mem_ren per pixel, data captured only on rvalid. Spurious rvalid in OUT is ignored.
- Degenerate frames:
  - max_x=0 -> done 1 cycle after start, no new_trans, no mem_ren.
  - 1x1 at base 0xFFFF -> single read at 0xFFFF, done.
  - base=0xFFF0, 4x8 frame -> addresses wrap modulo 2^16 (pixel (0,7) at 0x000C).
- start asserted during busy and on the FINISH cycle -> ignored. start in the IDLE cycle after done -> accepted.
